// File: rtl/cptra_ss_jtag_scan_initiator_if.sv
// Command/response bundle for the JTAG scan initiator.
// master: the side issuing scan commands; slave: the scan engine.
`timescale 1ns/1ps
interface cptra_ss_jtag_scan_initiator_if #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic               cmd_tlr_i;
    logic               cmd_ir_i;
    logic [LEN_W-1:0]   cmd_len_i;
    logic [MAX_LEN-1:0] cmd_data_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [MAX_LEN-1:0] rsp_data_o;
    logic               rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_tlr_i, cmd_ir_i, cmd_len_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_tlr_i, cmd_ir_i, cmd_len_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/cptra_ss_jtag_scan_initiator.sv
// JTAG host-side scan engine: IR/DR scan commands -> TCK/TMS/TDI, TDO capture.
// LSB-first shifting; every sequence starts and ends in Run-Test/Idle.
// Optional macro CPTRA_SS_JTAG_SCAN_TRST_EN: pulse TRST_N low after reset
// release before the initial TMS reset sequence; otherwise TRST_N is tied high.
`timescale 1ns/1ps
module cptra_ss_jtag_scan_initiator #(
    parameter int MAX_LEN = 64,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic clk,
    input  logic rst_b,
    cptra_ss_jtag_scan_initiator_if.slave bus,
    output logic busy_o,
    output logic jtag_tck_o,
    output logic jtag_tms_o,
    output logic jtag_tdi_o,
    output logic jtag_trst_n_o,
    input  logic jtag_tdo_i,
    input  logic jtag_tdoEn_i
);
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_INIT_TLR, S_IDLE, S_TLR, S_PRE, S_SHIFT, S_POST, S_RSP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_last;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic               ir_q, ir_d, err_q, err_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] cap_q, cap_d, sh_q, sh_d;
    logic               active, run_en, ph_wrap, tck_rise, tck_fall, len_bad, tdo_eff;

    // TMS level for TCK cycle c of state s; Shift leaves through Exit1 on its last bit
    function automatic logic tms_of(input state_t s, input logic [CNT_W-1:0] c,
                                    input logic ir, input logic [LEN_W-1:0] len);
        logic t;
        t = 1'b0;
        case (s)
            S_INIT_TLR, S_TLR: t = (c != CNT_W'(5));
            S_PRE:             t = ir ? (c < CNT_W'(2)) : (c == '0);
            S_SHIFT:           t = (c == CNT_W'(len) - CNT_W'(1));
            S_POST:            t = (c == '0);
            default:           t = 1'b0;
        endcase
        return t;
    endfunction

    assign active   = (state_q inside {S_INIT_TLR, S_TLR, S_PRE, S_SHIFT, S_POST});
    assign ph_wrap  = (ph_q == PH_W'(CLK_DIV - 1));
    assign tck_rise = active && run_en && ph_wrap && !tck_q;
    assign tck_fall = active && run_en && ph_wrap && tck_q;
    assign len_bad  = (bus.cmd_len_i == '0) || (bus.cmd_len_i > LEN_W'(MAX_LEN));
    assign tdo_eff  = jtag_tdoEn_i ? jtag_tdo_i : 1'b1;

`ifdef CPTRA_SS_JTAG_SCAN_TRST_EN
    localparam int TR_W = $clog2(2 * CLK_DIV + 1);
    logic [TR_W-1:0] trst_cnt_q;
    logic            trst_n_q;

    // Hold TRST_N low for one TCK period after reset release, then release for good
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            trst_cnt_q <= '0;
            trst_n_q   <= 1'b0;
        end else if (!trst_n_q) begin
            trst_cnt_q <= trst_cnt_q + TR_W'(1);
            if (trst_cnt_q == TR_W'(2 * CLK_DIV - 1)) trst_n_q <= 1'b1;
        end
    end

    assign run_en        = trst_n_q;
    assign jtag_trst_n_o = trst_n_q;
`else
    assign run_en        = 1'b1;
    assign jtag_trst_n_o = 1'b1;
`endif

    // Index of the final TCK cycle of the current sequence state
    always_comb begin
        case (state_q)
            S_INIT_TLR, S_TLR: cnt_last = CNT_W'(5);
            S_PRE:             cnt_last = ir_q ? CNT_W'(3) : CNT_W'(2);
            S_SHIFT:           cnt_last = CNT_W'(len_q) - CNT_W'(1);
            S_POST:            cnt_last = CNT_W'(1);
            default:           cnt_last = '0;
        endcase
    end

    // Next state, TCK phase, shift/capture data and the next pin levels
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = '0;
        tck_d   = tck_q;
        ir_d    = ir_q;
        len_d   = len_q;
        err_d   = err_q;
        cap_d   = cap_q;
        sh_d    = sh_q;
        if (active && run_en) begin
            ph_d = ph_wrap ? '0 : ph_q + PH_W'(1);
            if (ph_wrap) tck_d = ~tck_q;
        end
        if (tck_rise && state_q == S_SHIFT)
            cap_d = cap_q | (MAX_LEN'(tdo_eff) << cnt_q);
        if (tck_fall) begin
            if (state_q == S_SHIFT) sh_d = sh_q >> 1;
            if (cnt_q == cnt_last) begin
                cnt_d = '0;
                case (state_q)
                    S_INIT_TLR:    state_d = S_IDLE;
                    S_TLR, S_POST: state_d = S_RSP;
                    S_PRE:         state_d = S_SHIFT;
                    S_SHIFT:       state_d = S_POST;
                    default:       state_d = state_q;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    cap_d = '0;
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (bus.cmd_tlr_i) begin
                        state_d = S_TLR;
                    end else if (len_bad) begin
                        state_d = S_RSP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_PRE;
                        ir_d    = bus.cmd_ir_i;
                        len_d   = bus.cmd_len_i;
                        sh_d    = bus.cmd_data_i;
                    end
                end
            end
            S_RSP:   if (bus.rsp_ready_i) state_d = S_IDLE;
            default: state_d = state_d;
        endcase
        tms_d = tms_of(state_d, cnt_d, ir_d, len_d);
        tdi_d = (state_d == S_SHIFT) ? sh_d[0] : 1'b0;
    end

    // Sequencer state and registered pin levels
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_INIT_TLR;
            cnt_q   <= '0;
            ph_q    <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            err_q   <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ir_q    <= ir_d;
            len_q   <= len_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
        end
    end

    // Outgoing TDI bits; only meaningful after a command load
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign bus.cmd_ready_o = (state_q == S_IDLE);
    assign bus.rsp_valid_o = (state_q == S_RSP);
    assign bus.rsp_data_o  = cap_q;
    assign bus.rsp_err_o   = err_q;
    assign busy_o          = (state_q != S_IDLE);
    assign jtag_tck_o      = tck_q;
    assign jtag_tms_o      = tms_q;
    assign jtag_tdi_o      = tdi_q;
endmodule
